// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle; sign handling is done on magnitudes.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HI_Wr,
    input  logic             LO_Wr,
    input  logic [WIDTH-1:0] Wr_Data,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               w_busy;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Op[0]=0 selects the signed variants; both operands are reduced to magnitudes.
    assign w_a_neg = ~Op[0] & A[WIDTH-1];
    assign w_b_neg = ~Op[0] & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -A : A;
    assign w_b_mag = w_b_neg ? -B : B;

    // r_rem:r_q is the shared double-width working register for both operations.
    assign w_mul_sum   = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_rem, r_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

    assign w_prod     = {r_rem, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot_fix = r_div_zero ? '1 : (r_neg_q ? -r_q : r_q);
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = CALC;
            CALC:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (HI_Wr) r_hi <= Wr_Data;
                    if (LO_Wr) r_lo <= Wr_Data;
                    if (Start) begin
                        r_cnt      <= '0;
                        r_is_div   <= Op[1];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= Op[1] & (B == '0);
                        r_opnd     <= w_b_mag;
                        r_rem      <= '0;
                        r_q        <= w_a_mag;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_is_div) begin
                        r_rem <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_rem <= w_mul_sum[WIDTH:1];
                        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // A zero divisor leaves |A| as remainder, so the sign fix restores A itself.
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = w_busy;
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HI_Wr;
    logic        LO_Wr;
    logic [31:0] Wr_Data;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .HI_Wr(HI_Wr), .LO_Wr(LO_Wr), .Wr_Data(Wr_Data),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: 64-bit arithmetic; SV's / and % truncate toward zero with remainder sign of dividend.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic   [63:0]   res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (op)
            OP_MULT:  begin sp = sa * sb; res = sp; end
            OP_MULTU: begin up = ua * ub; res = up; end
            default: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == OP_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Presents Start for one edge (optionally with MT writes) and scrambles operands afterwards.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic hiWr, input logic loWr, input logic [31:0] data);
        Start = 1'b1; Op = op; A = a; B = b;
        HI_Wr = hiWr; LO_Wr = loWr; Wr_Data = data;
        @(posedge Clk); #1;
        Start = 1'b0; HI_Wr = 1'b0; LO_Wr = 1'b0;
        Op = 2'($urandom); A = $urandom; B = $urandom; Wr_Data = $urandom;
        if (hiWr) expHi = data;
        if (loWr) expLo = data;
        checkOutput("launch_busy", 64'(Busy), 64'(1));
    endtask

    task automatic waitDone(input int expLat, input string tag);
        int lat = 0;
        int busyCnt = 0;
        while (Done !== 1'b1 && lat < 40) begin
            if (Busy === 1'b1) busyCnt++;
            checkOutput({tag, "_hold_hi"}, 64'(HI), 64'(expHi));
            checkOutput({tag, "_hold_lo"}, 64'(LO), 64'(expLo));
            @(posedge Clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, "_busy_cycles"}, 64'(busyCnt), 64'(expLat));
        checkOutput({tag, "_busy_at_done"}, 64'(Busy), 64'(0));
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] r;
        r = refModel(op, a, b);
        launch(op, a, b, 1'b0, 1'b0, 32'h0);
        waitDone(33, tag);
        expHi = r[63:32];
        expLo = r[31:0];
        checkOutput({tag, "_hi"}, 64'(HI), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(LO), 64'(expLo));
    endtask

    task automatic idleCycle();
        @(posedge Clk); #1;
        checkOutput("done_pulse", 64'(Done), 64'(0));
        checkOutput("idle_busy", 64'(Busy), 64'(0));
    endtask

    task automatic mtWrite(input logic hiWr, input logic loWr, input logic [31:0] data);
        HI_Wr = hiWr; LO_Wr = loWr; Wr_Data = data;
        @(posedge Clk); #1;
        HI_Wr = 1'b0; LO_Wr = 1'b0;
        if (hiWr) expHi = data;
        if (loWr) expLo = data;
        checkOutput("mt_hi", 64'(HI), 64'(expHi));
        checkOutput("mt_lo", 64'(LO), 64'(expLo));
    endtask

    initial begin
        int doneSeen;
        logic [63:0] r;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        HI_Wr = 1'b0; LO_Wr = 1'b0; Wr_Data = '0;
        #12;
        checkOutput("rst_busy", 64'(Busy), 64'(0));
        checkOutput("rst_done", 64'(Done), 64'(0));
        checkOutput("rst_hi", 64'(HI), 64'(0));
        checkOutput("rst_lo", 64'(LO), 64'(0));
        @(negedge Clk); Reset_n = 1'b1;
        @(posedge Clk); #1;

        mtWrite(1'b1, 1'b1, 32'hDEAD_BEEF);
        mtWrite(1'b1, 1'b0, 32'h0BAD_F00D);

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        checkOutput("multu_max_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFE);
        checkOutput("multu_max_lo_const", 64'(LO), 64'h0000_0000_0000_0001);
        idleCycle();

        applyStimulus(OP_MULT, 32'hFFFF_FFF9, 32'h3, "mult_neg");
        checkOutput("mult_neg_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        checkOutput("mult_neg_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFEB);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'h2, "div_neg");
        checkOutput("div_neg_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        checkOutput("div_neg_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        idleCycle();

        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checkOutput("div_ovf_lo_const", 64'(LO), 64'h0000_0000_8000_0000);
        checkOutput("div_ovf_hi_const", 64'(HI), 64'h0);
        idleCycle();
        applyStimulus(OP_DIVU, 32'h5, 32'h0, "divu_zero");
        checkOutput("divu_zero_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFF);
        checkOutput("divu_zero_hi_const", 64'(HI), 64'h5);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, "divu_b2b");
        checkOutput("divu_b2b_lo_const", 64'(LO), 64'd14);
        checkOutput("divu_b2b_hi_const", 64'(HI), 64'd2);
        idleCycle();
        mtWrite(1'b0, 1'b1, 32'h0000_ABCD);
        checkOutput("mtlo_const", 64'(LO), 64'h0000_ABCD);
        applyStimulus(OP_DIV, 32'hFFFF_FFF0, 32'h0, "div_neg_zero");

        // Start and MTHI pulsed mid-operation must both be ignored.
        r = refModel(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        launch(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'h0);
        repeat (4) begin
            @(posedge Clk); #1;
            checkOutput("midop_hold_hi", 64'(HI), 64'(expHi));
        end
        Start = 1'b1; Op = OP_DIV; A = 32'd77; B = 32'd3; HI_Wr = 1'b1; Wr_Data = 32'h1234;
        @(posedge Clk); #1;
        Start = 1'b0; HI_Wr = 1'b0;
        waitDone(28, "midop");
        expHi = r[63:32];
        expLo = r[31:0];
        checkOutput("midop_hi", 64'(HI), 64'(expHi));
        checkOutput("midop_lo", 64'(LO), 64'(expLo));
        idleCycle();
        idleCycle();

        // MT write and Start in the same idle cycle: write lands, then the result overwrites it.
        r = refModel(OP_DIVU, 32'd1000, 32'd3);
        launch(OP_DIVU, 32'd1000, 32'd3, 1'b1, 1'b1, 32'h5555_5555);
        checkOutput("mtstart_hi", 64'(HI), 64'h5555_5555);
        checkOutput("mtstart_lo", 64'(LO), 64'h5555_5555);
        waitDone(33, "mtstart");
        expHi = r[63:32];
        expLo = r[31:0];
        checkOutput("mtstart_res_hi", 64'(HI), 64'(expHi));
        checkOutput("mtstart_res_lo", 64'(LO), 64'(expLo));

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra  = pickOperand();
            rb  = pickOperand();
            if ($urandom_range(0, 1) == 0) idleCycle();
            applyStimulus(rop, ra, rb, "rand");
        end
        idleCycle();

        // Reset in the middle of a divide: everything clears at once and no Done follows.
        launch(OP_DIV, 32'h7FFF_0000, 32'd9, 1'b0, 1'b0, 32'h0);
        repeat (9) @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(Busy), 64'(0));
        checkOutput("abort_done", 64'(Done), 64'(0));
        checkOutput("abort_hi", 64'(HI), 64'(0));
        checkOutput("abort_lo", 64'(LO), 64'(0));
        @(negedge Clk); Reset_n = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) doneSeen++;
        end
        checkOutput("abort_no_done", 64'(doneSeen), 64'(0));
        checkOutput("abort_idle", 64'(Busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
